// File: rtl/dec_fpr_wb_pkg.sv
// Shared types for the FPR writeback path: register width, writeback record and source tags.
package dec_fpr_wb_pkg;

  localparam int FLEN         = 64;
  localparam int NUM_WB_PORTS = 2;

  typedef struct packed {
    logic [4:0]      addr;
    logic [FLEN-1:0] data;
  } fpr_wb_t;

  typedef enum logic [1:0] {
    SRC_LSU = 2'd0,
    SRC_EXU = 2'd1,
    SRC_H   = 2'd2,
    SRC_H2  = 2'd3
  } wb_src_e;

  function automatic logic [31:0] addr_onehot(input logic [4:0] a);
    return 32'(1) << a;
  endfunction

endpackage

// File: rtl/dec_fpr_wb_fifo.sv
// In-order FPU result queue: single push, 0/1/2 pops per cycle, peeks head and head+1,
// and reports the set of destination registers it currently holds.
module dec_fpr_wb_fifo
  import dec_fpr_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fpr_wb_t                  push_entry,
  input  logic [1:0]               pop_cnt,
  output fpr_wb_t                  head,
  output fpr_wb_t                  head2,
  output logic                     head_v,
  output logic                     head2_v,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic [31:0]              pend_map
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fpr_wb_t         mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   idx;

  assign head    = mem[rd_ptr];
  assign head2   = mem[rd_ptr + PW'(1)];
  assign head_v  = (cnt != '0);
  assign head2_v = (cnt > CW'(1));

  // Payload storage needs no reset; occupancy is tracked by cnt alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_ptr + PW'(pop_cnt);
      cnt    <= cnt + CW'(push) - CW'(pop_cnt);
    end
  end

  always_comb begin
    pend_map = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < cnt) pend_map = pend_map | addr_onehot(mem[idx].addr);
    end
  end

endmodule

// File: rtl/dec_fpr_wb_arb.sv
// FPR writeback arbiter: merges LSU, EXU and queued FPU results onto two registered
// write ports, never writing one address twice per cycle, and exports a pending bitmap.
module dec_fpr_wb_arb
  import dec_fpr_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lsu_wb_valid,
  input  logic [4:0]               lsu_wb_addr,
  input  logic [FLEN-1:0]          lsu_wb_data,
  input  logic                     fpu_wb_valid,
  output logic                     fpu_wb_ready,
  input  logic [4:0]               fpu_wb_addr,
  input  logic [FLEN-1:0]          fpu_wb_data,
  input  logic                     exu_wb_valid,
  output logic                     exu_wb_ready,
  input  logic [4:0]               exu_wb_addr,
  input  logic [FLEN-1:0]          exu_wb_data,
  output logic                     wen0,
  output logic [4:0]               waddr0,
  output logic [FLEN-1:0]          wd0,
  output logic                     wen1,
  output logic [4:0]               waddr1,
  output logic [FLEN-1:0]          wd1,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic [31:0]              fwb_pend
);

  localparam int CW = $clog2(DEPTH) + 1;

  fpr_wb_t     head, head2, push_entry, cand_e, sel0, sel1;
  logic        head_v, head2_v, push, full, cand_v, sel_v0, sel_v1;
  logic [1:0]  pop_cnt, n_sel;
  logic [3:0]  issue;
  logic [31:0] fifo_pend;
  wb_src_e     order [4];

  assign full         = (fifo_cnt == CW'(DEPTH));
  assign fpu_wb_ready = !rst && (fifo_cnt < CW'(DEPTH));
  assign push         = fpu_wb_valid && fpu_wb_ready;
  assign push_entry   = '{addr: fpu_wb_addr, data: fpu_wb_data};
  assign exu_wb_ready = !rst && issue[SRC_EXU];
  assign pop_cnt      = {1'b0, issue[SRC_H]} + {1'b0, issue[SRC_H2]};

  dec_fpr_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop_cnt    (pop_cnt),
    .head       (head),
    .head2      (head2),
    .head_v     (head_v),
    .head2_v    (head2_v),
    .cnt        (fifo_cnt),
    .pend_map   (fifo_pend)
  );

  // A full queue demotes EXU behind both heads so FPU results cannot starve.
  always_comb begin
    order[0] = SRC_LSU;
    order[1] = SRC_EXU;
    order[2] = SRC_H;
    order[3] = SRC_H2;
    if (full) begin
      order[1] = SRC_H;
      order[2] = SRC_H2;
      order[3] = SRC_EXU;
    end
  end

  // Walk candidates in priority order; a match on an already chosen address is deferred.
  always_comb begin
    issue  = '0;
    n_sel  = '0;
    sel0   = '0;
    sel1   = '0;
    sel_v0 = 1'b0;
    sel_v1 = 1'b0;
    cand_v = 1'b0;
    cand_e = '0;
    for (int i = 0; i < 4; i++) begin
      case (order[i])
        SRC_LSU: begin cand_v = lsu_wb_valid; cand_e = '{addr: lsu_wb_addr, data: lsu_wb_data}; end
        SRC_EXU: begin cand_v = exu_wb_valid; cand_e = '{addr: exu_wb_addr, data: exu_wb_data}; end
        SRC_H:   begin cand_v = head_v;       cand_e = head;  end
        default: begin cand_v = head2_v && issue[SRC_H]; cand_e = head2; end
      endcase
      if (cand_v && n_sel == 2'd0) begin
        sel0            = cand_e;
        sel_v0          = 1'b1;
        n_sel           = 2'd1;
        issue[order[i]] = 1'b1;
      end else if (cand_v && n_sel == 2'd1 && cand_e.addr != sel0.addr) begin
        sel1            = cand_e;
        sel_v1          = 1'b1;
        n_sel           = 2'd2;
        issue[order[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wen0   <= 1'b0;
      waddr0 <= '0;
      wd0    <= '0;
      wen1   <= 1'b0;
      waddr1 <= '0;
      wd1    <= '0;
    end else begin
      wen0 <= sel_v0;
      wen1 <= sel_v1;
      if (sel_v0) begin
        waddr0 <= sel0.addr;
        wd0    <= sel0.data;
      end
      if (sel_v1) begin
        waddr1 <= sel1.addr;
        wd1    <= sel1.data;
      end
    end
  end

  assign fwb_pend = fifo_pend
                  | (wen0 ? addr_onehot(waddr0) : 32'd0)
                  | (wen1 ? addr_onehot(waddr1) : 32'd0);

  a_lsu_eligible: assert property (@(posedge clk) disable iff (rst)
    lsu_wb_valid |-> (sel_v0 && sel0.addr == lsu_wb_addr));

  a_lsu_fifo_waw: assert property (@(posedge clk) disable iff (rst)
    lsu_wb_valid |-> !fifo_pend[lsu_wb_addr]);

endmodule
